// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receiver with a programmable bit period.
// Bytes are delivered as one-cycle rx_valid pulses; framing errors as frame_err pulses.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_en,
    input  logic [DW-1:0] comp,
    input  logic          uart_rx,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic          frame_err,
    output logic          rx_busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [DW-1:0] ONE = 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_s_d_q;
    logic                   start_edge;

    state_e                 state_q, state_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DW-1:0]          comp_r_q, comp_r_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic [DW-1:0]          half_bit;
    logic [DW-1:0]          last_cnt;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign start_edge = rx_s_d_q & ~rx_s;
    assign half_bit   = comp_r_q >> 1;
    assign last_cnt   = comp_r_q - ONE;

    // Metastability chain on the raw pin plus one delay flop for edge detect
    always_ff @(posedge clk) begin
        if (rstn) begin
            sync_q   <= '1;
            rx_s_d_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], uart_rx};
            rx_s_d_q <= rx_s;
        end
    end

    // Next-state logic: start qualification, mid-bit sampling, stop check
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        comp_r_d    = comp_r_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (!rx_en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d  = START;
                        cnt_d    = '0;
                        comp_r_d = comp;
                    end
                end
                START: begin
                    if (cnt_q == half_bit) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            idx_d   = 3'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == last_cnt) begin
                        shreg_d = {rx_s, shreg_q[7:1]};
                        cnt_d   = '0;
                        if (idx_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == last_cnt) begin
                        if (rx_s) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Receiver state and registered outputs
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            comp_r_q    <= '0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            comp_r_q    <= comp_r_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed scenarios for the 8N1 receiver.
// A pin-level driver sends frames; a monitor counts output pulses.
`timescale 1ns/1ps
module tb_uart_rx_core;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          rx_en;
    logic [DW-1:0] comp;
    logic          uart_rx;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          rx_busy;

    int tests = 0;
    int fails = 0;

    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    logic [7:0] got[$];

    uart_rx_core #(.DW(DW), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_en    (rx_en),
        .comp     (comp),
        .uart_rx  (uart_rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt++;
            got.push_back(rx_data);
        end
        if (frame_err) ecnt++;
        if (rx_valid && frame_err) both++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame at the pin, bit period blen cycles
    task automatic send_byte(input logic [7:0] b, input int blen,
                             input logic stop_bit);
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        repeat (blen) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (blen) @(posedge clk);
            #1;
        end
        uart_rx = stop_bit;
        repeat (blen) @(posedge clk);
        #1;
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        rstn    = 1'b1;
        rx_en   = 1'b0;
        comp    = 16'd16;
        uart_rx = 1'b1;
        idle(3);
        @(negedge clk);
        tests++;
        if (rx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got %h want 00", rx_data);
        end
        tests++;
        if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses got v=%b e=%b want 0 0",
                     rx_valid, frame_err);
        end
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", rx_busy);
        end
        rstn  = 1'b0;
        rx_en = 1'b1;
        idle(4);
    endtask

    task automatic test_single();
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        comp = 16'd16;
        send_byte(8'h55, 16, 1'b1);
        idle(4);
        @(negedge clk);
        tests++;
        if (vcnt - v0 !== 1) begin
            fails++;
            $display("FAIL single_count got %0d want 1", vcnt - v0);
        end
        tests++;
        if (rx_data !== 8'h55) begin
            fails++;
            $display("FAIL single_data got %h want 55", rx_data);
        end
        tests++;
        if (ecnt - e0 !== 0) begin
            fails++;
            $display("FAIL single_ferr got %0d want 0", ecnt - e0);
        end
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_busy got %b want 0", rx_busy);
        end
    endtask

    task automatic test_back_to_back();
        int v0, e0, n;
        v0 = vcnt;
        e0 = ecnt;
        comp = 16'd10;
        idle(4);
        send_byte(8'hA3, 10, 1'b1);
        send_byte(8'h00, 10, 1'b1);
        send_byte(8'hFF, 10, 1'b1);
        idle(5);
        @(negedge clk);
        n = got.size();
        tests++;
        if (vcnt - v0 !== 3) begin
            fails++;
            $display("FAIL b2b_count got %0d want 3", vcnt - v0);
        end
        tests++;
        if (n < 3 || got[n-3] !== 8'hA3 || got[n-2] !== 8'h00 ||
            got[n-1] !== 8'hFF) begin
            fails++;
            $display("FAIL b2b_seq got %h %h %h want a3 00 ff",
                     (n > 2) ? got[n-3] : 8'hxx,
                     (n > 1) ? got[n-2] : 8'hxx,
                     (n > 0) ? got[n-1] : 8'hxx);
        end
        tests++;
        if (ecnt - e0 !== 0) begin
            fails++;
            $display("FAIL b2b_ferr got %0d want 0", ecnt - e0);
        end
    endtask

    task automatic test_frame_err();
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        comp = 16'd16;
        send_byte(8'h3C, 16, 1'b0);
        uart_rx = 1'b0;
        idle(20);
        @(negedge clk);
        tests++;
        if (ecnt - e0 !== 1) begin
            fails++;
            $display("FAIL ferr_count got %0d want 1", ecnt - e0);
        end
        tests++;
        if (vcnt - v0 !== 0) begin
            fails++;
            $display("FAIL ferr_valid got %0d want 0", vcnt - v0);
        end
        tests++;
        if (rx_data !== 8'hFF) begin
            fails++;
            $display("FAIL ferr_data got %h want ff", rx_data);
        end
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL ferr_low_busy got %b want 0", rx_busy);
        end
        idle(20);
        uart_rx = 1'b1;
        idle(60);
        @(negedge clk);
        tests++;
        if (rx_busy !== 1'b0 || vcnt - v0 !== 0 || ecnt - e0 !== 1) begin
            fails++;
            $display("FAIL ferr_release got busy=%b v=%0d e=%0d want 0 0 1",
                     rx_busy, vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_glitch();
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        comp = 16'd16;
        uart_rx = 1'b0;
        idle(5);
        uart_rx = 1'b1;
        @(negedge clk);
        tests++;
        if (rx_busy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_start got busy=%b want 1", rx_busy);
        end
        idle(20);
        @(negedge clk);
        tests++;
        if (rx_busy !== 1'b0) begin
            fails++;
            $display("FAIL glitch_abort got busy=%b want 0", rx_busy);
        end
        tests++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0) begin
            fails++;
            $display("FAIL glitch_pulses got v=%0d e=%0d want 0 0",
                     vcnt - v0, ecnt - e0);
        end
    endtask

    task automatic test_rx_en();
        int v0, e0;
        v0 = vcnt;
        e0 = ecnt;
        comp = 16'd16;
        fork
            send_byte(8'h81, 16, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (88) @(posedge clk);
                #2;
                tests++;
                if (rx_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL en_busy_before got %b want 1", rx_busy);
                end
                rx_en = 1'b0;
                @(posedge clk);
                @(negedge clk);
                tests++;
                if (rx_busy !== 1'b0) begin
                    fails++;
                    $display("FAIL en_abort got busy=%b want 0", rx_busy);
                end
            end
        join
        idle(10);
        @(negedge clk);
        tests++;
        if (vcnt - v0 !== 0 || ecnt - e0 !== 0 || rx_data !== 8'hFF) begin
            fails++;
            $display("FAIL en_quiet got v=%0d e=%0d d=%h want 0 0 ff",
                     vcnt - v0, ecnt - e0, rx_data);
        end
        rx_en = 1'b1;
        idle(4);
        send_byte(8'h81, 16, 1'b1);
        idle(4);
        @(negedge clk);
        tests++;
        if (vcnt - v0 !== 1 || rx_data !== 8'h81) begin
            fails++;
            $display("FAIL en_resume got v=%0d d=%h want 1 81",
                     vcnt - v0, rx_data);
        end
    endtask

    task automatic test_reset_midframe();
        int v0, e0;
        comp = 16'd16;
        fork
            send_byte(8'h5A, 16, 1'b1);
            begin
                @(posedge clk);
                #1;
                repeat (60) @(posedge clk);
                #1;
                rstn = 1'b1;
                @(posedge clk);
                #1;
                rstn  = 1'b0;
                rx_en = 1'b0;
                @(negedge clk);
                tests++;
                if (rx_data !== 8'h00 || rx_busy !== 1'b0 ||
                    rx_valid !== 1'b0 || frame_err !== 1'b0) begin
                    fails++;
                    $display("FAIL rst_mid got d=%h b=%b v=%b e=%b want 00 0 0 0",
                             rx_data, rx_busy, rx_valid, frame_err);
                end
            end
        join
        rx_en = 1'b1;
        idle(4);
        v0 = vcnt;
        e0 = ecnt;
        fork
            send_byte(8'hC6, 16, 1'b1);
            begin
                repeat (30) @(posedge clk);
                #1;
                comp = 16'd8;
            end
        join
        idle(4);
        @(negedge clk);
        tests++;
        if (vcnt - v0 !== 1 || rx_data !== 8'hC6) begin
            fails++;
            $display("FAIL comp_hold got v=%0d d=%h want 1 c6",
                     vcnt - v0, rx_data);
        end
        send_byte(8'h3A, 8, 1'b1);
        idle(4);
        @(negedge clk);
        tests++;
        if (vcnt - v0 !== 2 || rx_data !== 8'h3A || ecnt - e0 !== 0) begin
            fails++;
            $display("FAIL comp_new got v=%0d d=%h e=%0d want 2 3a 0",
                     vcnt - v0, rx_data, ecnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_rx_en();
        test_reset_midframe();
        tests++;
        if (both !== 0) begin
            fails++;
            $display("FAIL exclusive_pulses got %0d want 0", both);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive stage of the UART peripheral.
- Takes the raw uart_rx pin and recovers 8N1 frames (1 start, 8 data LSB first, 1 stop).
- Delivers each byte as a one-cycle valid pulse to the UART register/FIFO logic, which is in turn read over the Avalon slave wrapper.
- Bit timing comes from a programmable divider value written by software into the UART control register.

Parameters:
- DW, 16, width of the baud divider input comp.
- SYNC_STAGES, 2, number of metastability flip-flops on uart_rx (minimum 2).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-high (1 = reset asserted)
- rx_en  input  1  receiver enable; 0 aborts any frame and holds IDLE
- comp  input  DW  bit period in clk cycles; legal values 4..2^DW-1
- uart_rx  input  1  asynchronous serial line; idles high
- rx_data  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse, rx_data updated this cycle
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: any rising clk with rstn=1 applies it.
- Reset values:
  - rx_data=0x00, rx_valid=0, frame_err=0, rx_busy=0.
  - State IDLE.
  - Synchronizer flops and edge-detect flop = 1.
- Synchronizer and edge detect:
  - uart_rx passes through SYNC_STAGES flops to give rx_s.
  - rx_s_d is rx_s delayed one cycle.
  - A start edge is rx_s_d=1 and rx_s=0.
- Counters:
  - Bit counter cnt (DW bits) and bit index idx (3 bits).
  - comp_r (DW bits) latches comp on start-edge detection; comp changes mid-frame have no effect until the next frame.
- States:
  - IDLE: rx_busy=0. Start edge with rx_en=1 -> START; cnt=0; comp_r=comp.
  - START:
    - cnt increments each cycle.
    - At cnt == comp_r>>1, sample rx_s. If 1 (glitch/false start) -> IDLE, no pulse.
    - If 0 -> DATA; cnt=0; idx=0.
  - DATA:
    - At cnt == comp_r-1, shift rx_s into shift register MSB (LSB-first reception) and set cnt=0.
    - If idx==7 -> STOP, otherwise idx+1.
  - STOP: at cnt == comp_r-1, sample rx_s.
    - If 1: rx_data <= shift register and rx_valid=1 for exactly one cycle.
    - If 0: frame_err=1 for one cycle; rx_data unchanged.
    - Either way -> IDLE in the same cycle.
- Return to IDLE happens at mid-stop-bit, so back-to-back frames with one stop bit are received without loss.
- Break or stuck-low line: after frame_err, no new frame starts until rx_s has gone high and falls again (edge detect requirement).
- rx_en=0 in any state:
  - Next state is IDLE; no rx_valid or frame_err pulse.
  - rx_data is held.
  - Synchronizer keeps running.
- rx_valid and frame_err are never asserted together and are never asserted for more than one cycle.
- No backpressure: the consumer must take rx_data on rx_valid. rx_data stays stable until the next good frame.
- Latency:
  - rx_valid rises 9*comp_r + (comp_r>>1) + SYNC_STAGES + 1 cycles (±1) after the uart_rx falling edge at the pin.
- Arithmetic: all counter compares are unsigned, DW bits wide. comp<4 is illegal; behaviour is unspecified but must not lock up after reset.

Test Plan:
- Reset, then single frame 0x55, comp=16, rx_en=1 -> one rx_valid pulse, rx_data=0x55, frame_err never asserted, rx_busy low after the frame.
- Back-to-back frames 0xA3, 0x00, 0xFF with a single stop bit each, comp=10 -> three rx_valid pulses, rx_data sequence A3, 00, FF, no frame_err.
- Frame 0x3C with stop bit driven low, comp=16 -> frame_err pulse at mid-stop, no rx_valid, rx_data keeps the previous value. With the line then held low for 40 cycles and released, no further frame is detected.
- Low glitch of 5 cycles on an idle line, comp=16 -> START entered, aborted at the half-bit sample, no pulses, back in IDLE.
- rx_en dropped mid DATA bit 4 of frame 0x81 -> IDLE next cycle, no pulses. Re-enable, then send 0x81 -> rx_valid, rx_data=0x81.
- Reset asserted mid-frame, comp changed 16->8 during a frame:
  - Reset -> all outputs return to reset values at the next clk.
  - comp change -> the current frame is still timed with 16 and decodes correctly; the next frame uses 8.
